// File: rtl/boot_rom_bus_adapter.sv
// boot_rom_bus_adapter
// Bus-side front end of the boot ROM. Turns a req/gnt request channel and a valid/ready
// response channel into the ROM's en/addr/rdata interface. The ROM has 1-cycle read
// latency. Writes, misaligned addresses and out-of-range addresses complete with an
// error and never touch the ROM. Responses are buffered in a small FIFO when the
// consumer applies back-pressure.
//
// Ports
//   clk, rst_n   clock, asynchronous active-low reset
//   req_i/gnt_o  request handshake; addr_i byte address, we_i write (always an error)
//   rvalid_o/rready_i  response handshake; rdata_o data, err_o error flag
//   rom_en_o/rom_addr_o/rom_rdata_i  ROM port (rdata valid 1 cycle after en)
module boot_rom_bus_adapter #(
    parameter int unsigned ADDR_WIDTH = 12,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ROM_BYTES  = 2 ** ADDR_WIDTH,
    parameter int unsigned RSP_DEPTH  = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_i,
    output logic                  gnt_o,
    input  logic [31:0]           addr_i,
    input  logic                  we_i,
    output logic                  rvalid_o,
    input  logic                  rready_i,
    output logic [DATA_WIDTH-1:0] rdata_o,
    output logic                  err_o,
    output logic                  rom_en_o,
    output logic [ADDR_WIDTH-1:0] rom_addr_o,
    input  logic [DATA_WIDTH-1:0] rom_rdata_i
);

    localparam int unsigned PtrW = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
    localparam int unsigned CntW = $clog2(RSP_DEPTH + 1);

    typedef struct packed {
        logic                  err;
        logic [DATA_WIDTH-1:0] data;
    } rsp_t;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        if (p == PtrW'(RSP_DEPTH - 1)) begin
            return '0;
        end
        return p + 1'b1;
    endfunction

    logic            inflight_q, inflight_err_q;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [PtrW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    rsp_t            fifo_q [RSP_DEPTH];

    logic            fifo_empty, addr_err, accept, pop, fifo_pop, push;
    logic [CntW:0]   occ_after_pop;
    rsp_t            payload, rsp;

    always_comb begin
        fifo_empty = (cnt_q == '0);

        payload      = '0;
        payload.err  = inflight_err_q;
        payload.data = inflight_err_q ? '0 : rom_rdata_i;

        // FIFO head has priority; otherwise the fresh ROM result bypasses the FIFO.
        rvalid_o = inflight_q | ~fifo_empty;
        if (!fifo_empty) begin
            rsp = fifo_q[rptr_q];
        end else if (inflight_q) begin
            rsp = payload;
        end else begin
            rsp = '0;
        end
        rdata_o = rsp.data;
        err_o   = rsp.err;

        pop      = rvalid_o & rready_i;
        fifo_pop = pop & ~fifo_empty;
        // Bypassed payload that is consumed right away never enters the FIFO.
        push     = inflight_q & ~(fifo_empty & rready_i);

        // A pop in this cycle frees a slot for this cycle's request (rready_i -> gnt_o path).
        occ_after_pop = {1'b0, cnt_q} + (CntW + 1)'(inflight_q) - (CntW + 1)'(pop);
        gnt_o  = req_i & rst_n & (occ_after_pop < (CntW + 1)'(RSP_DEPTH));
        accept = gnt_o;

        addr_err = we_i | (|addr_i[1:0]) | ({32'b0, addr_i} >= 64'(ROM_BYTES));

        rom_en_o   = accept & ~addr_err;
        rom_addr_o = rom_en_o ? addr_i[ADDR_WIDTH-1:0] : '0;

        cnt_d  = cnt_q + CntW'(push) - CntW'(fifo_pop);
        wptr_d = push ? ptr_inc(wptr_q) : wptr_q;
        rptr_d = fifo_pop ? ptr_inc(rptr_q) : rptr_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inflight_q     <= 1'b0;
            inflight_err_q <= 1'b0;
            cnt_q          <= '0;
            wptr_q         <= '0;
            rptr_q         <= '0;
        end else begin
            inflight_q     <= accept;
            inflight_err_q <= accept & addr_err;
            cnt_q          <= cnt_d;
            wptr_q         <= wptr_d;
            rptr_q         <= rptr_d;
        end
    end

    // Storage needs no reset: it is only read while cnt_q says the entry is live.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_q[wptr_q] <= payload;
        end
    end

endmodule

// File: tb/tb_boot_rom_bus_adapter.sv
module tb_boot_rom_bus_adapter;

    localparam int unsigned AW    = 8;
    localparam int unsigned DW    = 32;
    localparam int unsigned DEPTH = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          req_i = 1'b0, we_i = 1'b0, rready_i = 1'b0;
    logic [31:0]   addr_i = '0;
    logic          gnt_o, rvalid_o, err_o, rom_en_o;
    logic [DW-1:0] rdata_o;
    logic [AW-1:0] rom_addr_o;
    logic [DW-1:0] rom_rdata = '0;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] word(input int unsigned i);
        return 32'hB007_0000 + i * 32'h0001_0111;
    endfunction

    // ROM model: 1-cycle read latency, holds last data when not enabled.
    always @(posedge clk) begin
        if (rom_en_o) rom_rdata <= word(int'(rom_addr_o[AW-1:2]));
    end

    boot_rom_bus_adapter #(
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW),
        .RSP_DEPTH (DEPTH)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_i      (req_i),
        .gnt_o      (gnt_o),
        .addr_i     (addr_i),
        .we_i       (we_i),
        .rvalid_o   (rvalid_o),
        .rready_i   (rready_i),
        .rdata_o    (rdata_o),
        .err_o      (err_o),
        .rom_en_o   (rom_en_o),
        .rom_addr_o (rom_addr_o),
        .rom_rdata_i(rom_rdata)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        assert (got === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic req, input logic [31:0] addr, input logic we,
                         input logic rdy);
        req_i = req; addr_i = addr; we_i = we; rready_i = rdy;
        #2;
    endtask

    task automatic rsp(input string tag, input logic v, input logic [DW-1:0] d,
                       input logic e);
        chk({tag, ".rvalid"}, 64'(rvalid_o), 64'(v));
        chk({tag, ".rdata"}, 64'(rdata_o), 64'(d));
        chk({tag, ".err"}, 64'(err_o), 64'(e));
    endtask

    logic [DW:0] q[$];
    logic        held;
    logic        exp_gnt, good;
    logic [DW:0] exp_rsp;

    initial begin
        // Reset state, with a request presented to show gnt_o is masked.
        drive(1'b1, 32'h44, 1'b0, 1'b1);
        chk("rst.gnt", 64'(gnt_o), 64'(0));
        chk("rst.rom_en", 64'(rom_en_o), 64'(0));
        chk("rst.rom_addr", 64'(rom_addr_o), 64'(0));
        rsp("rst", 1'b0, '0, 1'b0);
        req_i = 1'b0;
        #20;
        rst_n = 1'b1;
        tick();

        // 1: back-to-back reads, rready held high
        for (int i = 0; i < 5; i++) begin
            drive(i < 4, 32'(i * 4), 1'b0, 1'b1);
            chk($sformatf("t1.gnt%0d", i), 64'(gnt_o), 64'(i < 4));
            chk($sformatf("t1.rom_en%0d", i), 64'(rom_en_o), 64'(i < 4));
            chk($sformatf("t1.rom_addr%0d", i), 64'(rom_addr_o), 64'(i < 4 ? i * 4 : 0));
            if (i == 0) rsp("t1.r0", 1'b0, '0, 1'b0);
            else rsp($sformatf("t1.r%0d", i), 1'b1, word(i - 1), 1'b0);
            tick();
        end
        drive(1'b0, '0, 1'b0, 1'b1);
        rsp("t1.idle", 1'b0, '0, 1'b0);

        // 2: back-pressure, third request stalls until one pop
        tick();
        drive(1'b1, 32'h0, 1'b0, 1'b0);
        chk("t2.gnt0", 64'(gnt_o), 64'(1));
        tick();
        drive(1'b1, 32'h4, 1'b0, 1'b0);
        chk("t2.gnt1", 64'(gnt_o), 64'(1));
        rsp("t2.byp", 1'b1, word(0), 1'b0);
        tick();
        drive(1'b1, 32'h8, 1'b0, 1'b0);
        chk("t2.gnt2_stall", 64'(gnt_o), 64'(0));
        chk("t2.rom_en_stall", 64'(rom_en_o), 64'(0));
        tick();
        drive(1'b1, 32'h8, 1'b0, 1'b0);
        chk("t2.gnt2_full", 64'(gnt_o), 64'(0));
        rsp("t2.hold", 1'b1, word(0), 1'b0);
        drive(1'b1, 32'h8, 1'b0, 1'b1);
        chk("t2.gnt2_pop", 64'(gnt_o), 64'(1));
        chk("t2.rom_addr2", 64'(rom_addr_o), 64'(8));
        rsp("t2.d0", 1'b1, word(0), 1'b0);
        tick();
        drive(1'b0, '0, 1'b0, 1'b0);
        rsp("t2.head1", 1'b1, word(1), 1'b0);
        tick();
        drive(1'b0, '0, 1'b0, 1'b1);
        rsp("t2.d1", 1'b1, word(1), 1'b0);
        tick();
        drive(1'b0, '0, 1'b0, 1'b1);
        rsp("t2.d2", 1'b1, word(2), 1'b0);
        tick();
        drive(1'b0, '0, 1'b0, 1'b1);
        rsp("t2.empty", 1'b0, '0, 1'b0);

        // 3: write is an error, ROM untouched
        tick();
        drive(1'b1, 32'h10, 1'b1, 1'b1);
        chk("t3.gnt", 64'(gnt_o), 64'(1));
        chk("t3.rom_en", 64'(rom_en_o), 64'(0));
        tick();
        drive(1'b0, '0, 1'b0, 1'b1);
        rsp("t3.rsp", 1'b1, '0, 1'b1);

        // 4: misaligned, out of range (== ROM_BYTES), then good
        tick();
        drive(1'b1, 32'h6, 1'b0, 1'b1);
        chk("t4.rom_en_mis", 64'(rom_en_o), 64'(0));
        tick();
        drive(1'b1, 32'(2 ** AW), 1'b0, 1'b1);
        chk("t4.rom_en_oor", 64'(rom_en_o), 64'(0));
        rsp("t4.mis", 1'b1, '0, 1'b1);
        tick();
        drive(1'b1, 32'h0, 1'b0, 1'b1);
        chk("t4.rom_en_ok", 64'(rom_en_o), 64'(1));
        rsp("t4.oor", 1'b1, '0, 1'b1);
        tick();
        drive(1'b0, '0, 1'b0, 1'b1);
        rsp("t4.ok", 1'b1, word(0), 1'b0);

        // 5: reset with buffered responses
        tick();
        drive(1'b1, 32'h0, 1'b0, 1'b0);
        tick();
        drive(1'b1, 32'h4, 1'b0, 1'b0);
        tick();
        drive(1'b1, 32'h8, 1'b0, 1'b0);
        rsp("t5.buffered", 1'b1, word(0), 1'b0);
        rst_n = 1'b0;
        #1;
        rsp("t5.in_rst", 1'b0, '0, 1'b0);
        chk("t5.gnt_rst", 64'(gnt_o), 64'(0));
        req_i = 1'b0;
        tick();
        tick();
        #3;
        rst_n = 1'b1;
        tick();
        drive(1'b0, '0, 1'b0, 1'b1);
        rsp("t5.no_stale0", 1'b0, '0, 1'b0);
        tick();
        drive(1'b1, 32'h4, 1'b0, 1'b1);
        rsp("t5.no_stale1", 1'b0, '0, 1'b0);
        chk("t5.gnt", 64'(gnt_o), 64'(1));
        tick();
        drive(1'b0, '0, 1'b0, 1'b1);
        rsp("t5.rd", 1'b1, word(1), 1'b0);
        tick();

        // 6: random traffic against a scoreboard
        held = 1'b0;
        for (int c = 0; c < 10000; c++) begin
            if (!held) begin
                int unsigned k;
                k = $urandom_range(0, 9);
                req_i  = ($urandom_range(0, 3) != 0);
                we_i   = (k == 8);
                case (k)
                    6:       addr_i = {24'b0, 6'($urandom_range(0, 63)), 2'b10};
                    7:       addr_i = 32'(2 ** AW) + 32'($urandom_range(0, 1023) * 4);
                    default: addr_i = {24'b0, 6'($urandom_range(0, 63)), 2'b00};
                endcase
            end
            rready_i = ($urandom_range(0, 9) < 6);
            #2;
            chk("t6.rvalid", 64'(rvalid_o), 64'(q.size() != 0));
            exp_gnt = req_i && ((q.size() - ((q.size() != 0 && rready_i) ? 1 : 0)) < DEPTH);
            chk("t6.gnt", 64'(gnt_o), 64'(exp_gnt));
            good = !we_i && addr_i[1:0] == 2'b00 && addr_i < 32'(2 ** AW);
            chk("t6.rom_en", 64'(rom_en_o), 64'(exp_gnt && good));
            if (q.size() != 0) begin
                chk("t6.rsp", {31'b0, err_o, rdata_o}, 64'(q[0]));
                if (rready_i) void'(q.pop_front());
            end
            if (exp_gnt) begin
                exp_rsp = good ? {1'b0, word(int'(addr_i[AW-1:2]))} : {1'b1, 32'b0};
                q.push_back(exp_rsp);
            end
            held = req_i && !exp_gnt;
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
